// File: rtl/alu_bist_driver.sv
// ALU built-in self-test driver: walks all eleven opcodes with LFSR operands and
// folds every ALU response into a MISR signature that is compared with a golden value.

module alu_bist_driver #(
   parameter int          DATA_W  = 8,
   parameter int          OUT_W   = 16,
   parameter int          VECTORS = 16,
   parameter int          LATENCY = 1,
   parameter logic [15:0] SEED    = 16'hACE1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [OUT_W-1:0]  golden_sig,
   output logic              alu_en,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_opcode,
   input  logic [OUT_W-1:0]  alu_out,
   input  logic              alu_cout,
   input  logic              alu_ouflag,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [OUT_W-1:0]  signature
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] OP_DIV    = 4'b1100;
   localparam logic [3:0] IDX_LAST  = 4'd10;
   localparam logic [7:0] VEC_LAST  = 8'(VECTORS - 1);
   localparam logic [2:0] WAIT_LAST = 3'(LATENCY - 1);

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] m,
                                                  input logic [OUT_W-1:0] r,
                                                  input logic             c,
                                                  input logic             f);
      return {m[OUT_W-2:0], m[15] ^ m[13] ^ m[12] ^ m[10]}
             ^ r ^ {{(OUT_W-2){1'b0}}, c, f};
   endfunction

   function automatic logic [3:0] op_of(input logic [3:0] idx);
      case (idx)
         4'd0:    return 4'b1111;
         4'd1:    return 4'b1110;
         4'd2:    return 4'b1101;
         4'd3:    return 4'b1100;
         4'd4:    return 4'b1011;
         4'd5:    return 4'b1010;
         4'd6:    return 4'b0111;
         4'd7:    return 4'b0110;
         4'd8:    return 4'b0101;
         4'd9:    return 4'b0100;
         4'd10:   return 4'b0011;
         default: return 4'b0000;
      endcase
   endfunction

   state_t              state_q, state_d;
   logic [15:0]         lfsr_q, lfsr_d;
   logic [OUT_W-1:0]    misr_q, misr_d;
   logic [3:0]          idx_q, idx_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [2:0]          wcnt_q, wcnt_d;
   logic                alu_en_q, alu_en_d;
   logic [DATA_W-1:0]   alu_a_q, alu_a_d;
   logic [DATA_W-1:0]   alu_b_q, alu_b_d;
   logic [3:0]          alu_op_q, alu_op_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;

   logic                load_issue_s;
   logic [15:0]         issue_lfsr_s;
   logic [3:0]          issue_idx_s;
   logic [3:0]          issue_op_s;
   logic [OUT_W-1:0]    misr_next_s;

   // Next-state, counter, MISR and registered-output computation
   always_comb begin
      state_d      = state_q;
      lfsr_d       = lfsr_q;
      misr_d       = misr_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      wcnt_d       = wcnt_q;
      alu_en_d     = 1'b0;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      busy_d       = busy_q;
      done_d       = done_q;
      pass_d       = pass_q;
      load_issue_s = 1'b0;
      issue_lfsr_s = lfsr_q;
      issue_idx_s  = idx_q;
      issue_op_s   = 4'b0000;
      misr_next_s  = misr_step(misr_q, alu_out, alu_cout, alu_ouflag);

      if (abort) begin
         state_d  = S_IDLE;
         busy_d   = 1'b0;
         done_d   = 1'b0;
         pass_d   = 1'b0;
         alu_a_d  = '0;
         alu_b_d  = '0;
         alu_op_d = 4'b0000;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_d      = S_ISSUE;
                  misr_d       = '0;
                  lfsr_d       = SEED;
                  idx_d        = 4'd0;
                  cnt_d        = 8'd0;
                  busy_d       = 1'b1;
                  done_d       = 1'b0;
                  pass_d       = 1'b0;
                  load_issue_s = 1'b1;
                  issue_lfsr_s = SEED;
                  issue_idx_s  = 4'd0;
               end else begin
                  state_d = state_q;
               end
            end
            S_ISSUE: begin
               state_d = S_WAIT;
               wcnt_d  = 3'd0;
            end
            S_WAIT: begin
               if (wcnt_q == WAIT_LAST) begin
                  misr_d = misr_next_s;
                  lfsr_d = lfsr_step(lfsr_q);
                  if (cnt_q == VEC_LAST) begin
                     cnt_d = 8'd0;
                     if (idx_q == IDX_LAST) begin
                        // pass compares the signature including this final capture
                        state_d  = S_DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        pass_d   = (misr_next_s == golden_sig);
                        alu_a_d  = '0;
                        alu_b_d  = '0;
                        alu_op_d = 4'b0000;
                     end else begin
                        state_d      = S_ISSUE;
                        idx_d        = idx_q + 4'd1;
                        load_issue_s = 1'b1;
                        issue_lfsr_s = lfsr_step(lfsr_q);
                        issue_idx_s  = idx_q + 4'd1;
                     end
                  end else begin
                     state_d      = S_ISSUE;
                     cnt_d        = cnt_q + 8'd1;
                     load_issue_s = 1'b1;
                     issue_lfsr_s = lfsr_step(lfsr_q);
                     issue_idx_s  = idx_q;
                  end
               end else begin
                  wcnt_d = wcnt_q + 3'd1;
               end
            end
            default: begin
               state_d  = S_IDLE;
               busy_d   = 1'b0;
               done_d   = 1'b0;
               pass_d   = 1'b0;
               alu_a_d  = '0;
               alu_b_d  = '0;
               alu_op_d = 4'b0000;
            end
         endcase
      end

      // Operands for the upcoming ISSUE cycle, with the divide-by-zero guard
      if (load_issue_s) begin
         issue_op_s = op_of(issue_idx_s);
         alu_en_d   = 1'b1;
         alu_a_d    = issue_lfsr_s[15 -: DATA_W];
         alu_op_d   = issue_op_s;
         if ((issue_op_s == OP_DIV) && (issue_lfsr_s[DATA_W-1:0] == '0)) begin
            alu_b_d = {{(DATA_W-1){1'b0}}, 1'b1};
         end else begin
            alu_b_d = issue_lfsr_s[DATA_W-1:0];
         end
      end else begin
         issue_op_s = 4'b0000;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         lfsr_q   <= SEED;
         misr_q   <= '0;
         idx_q    <= 4'd0;
         cnt_q    <= 8'd0;
         wcnt_q   <= 3'd0;
         alu_en_q <= 1'b0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= 4'b0000;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         misr_q   <= misr_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         wcnt_q   <= wcnt_d;
         alu_en_q <= alu_en_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_op_q <= alu_op_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
      end
   end

   assign alu_en     = alu_en_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_op_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign signature  = misr_q;

endmodule

// File: tb/tb_alu_bist_driver.sv
// Scoreboard bench for alu_bist_driver: three instances with different LATENCY/VECTORS/SEED,
// each driving a behavioural pipelined ALU; a monitor checks issues, holds and final signatures.

module tb_alu_bist_driver;

   localparam int          L0 = 1, L1 = 3, L2 = 2;
   localparam int          V0 = 1, V1 = 1, V2 = 3;
   localparam logic [15:0] S0 = 16'hACE1, S1 = 16'h4200, S2 = 16'hACE1;

   typedef struct packed { logic [3:0] op; logic [7:0] a; logic [7:0] b; } iss_t;
   typedef struct packed { logic [15:0] sig; logic pass; } dn_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  rstn_v, start_v, abort_v;
   logic [2:0]  en_v, busy_v, done_v, pass_v, cout_v, ouf_v;
   logic [7:0]  a_v [3];
   logic [7:0]  b_v [3];
   logic [3:0]  op_v [3];
   logic [15:0] gold_v [3];
   logic [15:0] out_v [3];
   logic [15:0] sig_v [3];
   logic [17:0] pipe [3][3] = '{default: '0};

   iss_t exp_iss [3][$];
   dn_t  exp_dn  [3][$];
   int   n_checks = 0;
   int   n_errors = 0;

   alu_bist_driver #(.DATA_W(8), .OUT_W(16), .VECTORS(V0), .LATENCY(L0), .SEED(S0)) u_dut0 (
      .clk(clk), .reset_n(rstn_v[0]), .start(start_v[0]), .abort(abort_v[0]),
      .golden_sig(gold_v[0]), .alu_en(en_v[0]), .alu_a(a_v[0]), .alu_b(b_v[0]),
      .alu_opcode(op_v[0]), .alu_out(out_v[0]), .alu_cout(cout_v[0]), .alu_ouflag(ouf_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .signature(sig_v[0]));

   alu_bist_driver #(.DATA_W(8), .OUT_W(16), .VECTORS(V1), .LATENCY(L1), .SEED(S1)) u_dut1 (
      .clk(clk), .reset_n(rstn_v[1]), .start(start_v[1]), .abort(abort_v[1]),
      .golden_sig(gold_v[1]), .alu_en(en_v[1]), .alu_a(a_v[1]), .alu_b(b_v[1]),
      .alu_opcode(op_v[1]), .alu_out(out_v[1]), .alu_cout(cout_v[1]), .alu_ouflag(ouf_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .signature(sig_v[1]));

   alu_bist_driver #(.DATA_W(8), .OUT_W(16), .VECTORS(V2), .LATENCY(L2), .SEED(S2)) u_dut2 (
      .clk(clk), .reset_n(rstn_v[2]), .start(start_v[2]), .abort(abort_v[2]),
      .golden_sig(gold_v[2]), .alu_en(en_v[2]), .alu_a(a_v[2]), .alu_b(b_v[2]),
      .alu_opcode(op_v[2]), .alu_out(out_v[2]), .alu_cout(cout_v[2]), .alu_ouflag(ouf_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .signature(sig_v[2]));

   function automatic int lat_of(input int i);
      return (i == 0) ? L0 : (i == 1) ? L1 : L2;
   endfunction
   function automatic int vec_n(input int i);
      return (i == 0) ? V0 : (i == 1) ? V1 : V2;
   endfunction
   function automatic logic [15:0] seed_of(input int i);
      return (i == 0) ? S0 : (i == 1) ? S1 : S2;
   endfunction

   function automatic logic [3:0] opc(input int idx);
      case (idx)
         0: return 4'b1111;  1: return 4'b1110;  2: return 4'b1101;  3: return 4'b1100;
         4: return 4'b1011;  5: return 4'b1010;  6: return 4'b0111;  7: return 4'b0110;
         8: return 4'b0101;  9: return 4'b0100; 10: return 4'b0011;
         default: return 4'b0000;
      endcase
   endfunction

   // Reference ALU: {out[15:0], cout, ouflag}
   function automatic logic [17:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [8:0]  w;
      logic [15:0] o;
      logic        c, f;
      w = 9'd0; o = 16'h0000; c = 1'b0; f = 1'b0;
      case (op)
         4'b1111: begin w = {1'b0, a} + {1'b0, b}; o = {7'd0, w}; c = w[8]; f = (a[7] == b[7]) && (w[7] != a[7]); end
         4'b1110: begin w = {1'b0, a} - {1'b0, b}; o = {7'd0, w}; c = w[8]; f = (a[7] != b[7]) && (w[7] != a[7]); end
         4'b1101: begin o = 16'(a) * 16'(b); f = |o[15:8]; end
         4'b1100: begin
            if (b == 8'h00) begin o = 16'hFFFF; f = 1'b1; end
            else begin o = {a % b, a / b}; end
         end
         4'b1011: begin o = 16'(a) + 16'd1; c = (a == 8'hFF); f = (a == 8'h7F); end
         4'b1010: begin w = {1'b0, a} - 9'd1; o = {7'd0, w}; c = w[8]; f = (a == 8'h80); end
         4'b0111: o = {8'h00, a & b};
         4'b0110: o = {8'h00, a | b};
         4'b0101: o = {8'h00, a ^ b};
         4'b0100: o = {8'h00, ~a};
         4'b0011: o = {8'h00, ~(a & b)};
         default: o = 16'h0000;
      endcase
      return {o, c, f};
   endfunction

   function automatic logic [15:0] lfsr_m(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction
   function automatic logic [15:0] misr_m(input logic [15:0] m, input logic [17:0] r);
      return lfsr_m(m) ^ r[17:2] ^ {14'd0, r[1], r[0]};
   endfunction
   function automatic iss_t vec_of(input logic [15:0] l, input int idx);
      iss_t v;
      v.op = opc(idx);
      v.a  = l[15:8];
      v.b  = ((v.op == 4'b1100) && (l[7:0] == 8'h00)) ? 8'h01 : l[7:0];
      return v;
   endfunction
   function automatic logic [15:0] model_sig(input logic [15:0] seed, input int vectors, input int nvec);
      logic [15:0] l, m;
      iss_t v;
      l = seed; m = 16'h0000;
      for (int k = 0; k < nvec; k++) begin
         v = vec_of(l, k / vectors);
         m = misr_m(m, alu_fn(v.op, v.a, v.b));
         l = lfsr_m(l);
      end
      return m;
   endfunction

   // Behavioural ALUs, registered: stage k holds the response k+1 clocks after issue
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (en_v[i]) pipe[i][0] <= alu_fn(op_v[i], a_v[i], b_v[i]);
         pipe[i][1] <= pipe[i][0];
         pipe[i][2] <= pipe[i][1];
      end
   end
   assign {out_v[0], cout_v[0], ouf_v[0]} = pipe[0][L0-1];
   assign {out_v[1], cout_v[1], ouf_v[1]} = pipe[1][L1-1];
   assign {out_v[2], cout_v[2], ouf_v[2]} = pipe[2][L2-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_zero(input int i, input string name);
      chk(name, 32'({en_v[i], op_v[i], a_v[i], b_v[i], busy_v[i], done_v[i], pass_v[i]}), 32'd0);
      chk({name, "_sig"}, 32'(sig_v[i]), 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic start_run(input int i, input logic [15:0] gmask, input logic exp_pass);
      logic [15:0] l, s;
      l = seed_of(i);
      for (int k = 0; k < 11 * vec_n(i); k++) begin
         exp_iss[i].push_back(vec_of(l, k / vec_n(i)));
         l = lfsr_m(l);
      end
      s = model_sig(seed_of(i), vec_n(i), 11 * vec_n(i));
      gold_v[i] = s ^ gmask;
      exp_dn[i].push_back({s, exp_pass});
      tick();
      start_v[i] = 1'b1;
      tick();
      start_v[i] = 1'b0;
      chk("busy_rise", 32'(busy_v[i]), 32'd1);
      chk("done_clear", 32'({done_v[i], pass_v[i]}), 32'd0);
   endtask

   task automatic wait_en(input int i, input int n);
      int seen, cyc;
      seen = 0; cyc = 0;
      while (seen < n && cyc < 500) begin
         @(negedge clk);
         cyc++;
         if (en_v[i]) seen++;
      end
      if (seen < n) chk("wait_en_timeout", 32'(seen), 32'(n));
   endtask

   task automatic wait_done(input int i);
      int cyc;
      cyc = 0;
      while (!done_v[i] && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_reached", 32'(done_v[i]), 32'd1);
   endtask

   task automatic flush(input int i);
      exp_iss[i].delete();
      exp_dn[i].delete();
   endtask

   // Monitor: pops expected issues/results whenever the DUT presents them
   initial begin
      int   gap [3];
      int   bcnt [3];
      logic [2:0] busy_p, done_p, in_run;
      iss_t held [3];
      iss_t e;
      dn_t  d;
      busy_p = 3'b000; done_p = 3'b000; in_run = 3'b000;
      for (int i = 0; i < 3; i++) begin gap[i] = 0; bcnt[i] = 0; held[i] = '0; end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (rstn_v[i] !== 1'b1) begin
               busy_p[i] = 1'b0; done_p[i] = 1'b0; in_run[i] = 1'b0; bcnt[i] = 0;
            end else begin
               if (busy_v[i] && !busy_p[i]) begin bcnt[i] = 0; in_run[i] = 1'b0; end
               if (busy_v[i]) bcnt[i]++;
               if (en_v[i]) begin
                  if (exp_iss[i].size() == 0) begin
                     chk("unexpected_issue", 32'd1, 32'd0);
                  end else begin
                     e = exp_iss[i].pop_front();
                     chk("issue_op", 32'(op_v[i]), 32'(e.op));
                     chk("issue_a", 32'(a_v[i]), 32'(e.a));
                     chk("issue_b", 32'(b_v[i]), 32'(e.b));
                  end
                  if (in_run[i]) chk("issue_gap", 32'(gap[i]), 32'(lat_of(i)));
                  in_run[i] = 1'b1;
                  gap[i] = 0;
                  held[i] = {op_v[i], a_v[i], b_v[i]};
               end else if (busy_v[i]) begin
                  gap[i]++;
                  chk("operand_hold", 32'({op_v[i], a_v[i], b_v[i]}), 32'(held[i]));
               end else begin
                  chk("idle_zero", 32'({en_v[i], op_v[i], a_v[i], b_v[i]}), 32'd0);
               end
               if (done_v[i] && !done_p[i]) begin
                  if (exp_dn[i].size() == 0) begin
                     chk("unexpected_done", 32'd1, 32'd0);
                  end else begin
                     d = exp_dn[i].pop_front();
                     chk("signature", 32'(sig_v[i]), 32'(d.sig));
                     chk("pass", 32'(pass_v[i]), 32'(d.pass));
                     chk("busy_cycles", 32'(bcnt[i]), 32'(11 * vec_n(i) * (1 + lat_of(i))));
                  end
               end
               busy_p[i] = busy_v[i];
               done_p[i] = done_v[i];
            end
         end
      end
   end

   // Directed stimulus
   initial begin
      rstn_v  = 3'b000;
      start_v = 3'b111;
      abort_v = 3'b000;
      for (int i = 0; i < 3; i++) gold_v[i] = 16'h0000;

      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) chk_zero(i, "reset_outputs");
      tick();
      start_v = 3'b000;
      tick();
      rstn_v = 3'b111;
      repeat (3) tick();
      chk("idle_after_reset", 32'({busy_v, done_v}), 32'd0);

      // Full run, matching golden; first vector is the seed split into A/B
      start_run(0, 16'h0000, 1'b1);
      chk("first_op", 32'(op_v[0]), 32'h0000_000F);
      chk("first_a", 32'(a_v[0]), 32'h0000_00AC);
      chk("first_b", 32'(b_v[0]), 32'h0000_00E1);
      wait_done(0);

      // Rerun from DONE with a wrong golden; a start pulse mid-run must be ignored
      start_run(0, 16'h0001, 1'b0);
      wait_en(0, 3);
      tick();
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      wait_done(0);
      gold_v[0] = model_sig(S0, V0, 11 * V0);
      repeat (3) tick();
      chk("pass_after_golden_change", 32'(pass_v[0]), 32'd0);
      chk("done_held", 32'(done_v[0]), 32'd1);

      // Abort during the fifth vector: four captures are kept in the MISR
      start_run(0, 16'h0000, 1'b1);
      wait_en(0, 5);
      tick();
      abort_v[0] = 1'b1;
      tick();
      abort_v[0] = 1'b0;
      flush(0);
      chk("abort_state", 32'({en_v[0], busy_v[0], done_v[0], pass_v[0]}), 32'd0);
      chk("abort_misr_hold", 32'(sig_v[0]), 32'(model_sig(S0, V0, 4)));

      // start and abort together: abort wins
      tick();
      start_v[0] = 1'b1;
      abort_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      abort_v[0] = 1'b0;
      chk("start_abort_busy", 32'({busy_v[0], en_v[0]}), 32'd0);
      repeat (2) tick();
      chk("start_abort_idle", 32'(busy_v[0]), 32'd0);

      // Asynchronous reset mid-run clears everything at once
      start_run(0, 16'h0000, 1'b1);
      wait_en(0, 4);
      tick();
      rstn_v[0] = 1'b0;
      #1;
      flush(0);
      chk_zero(0, "reset_midrun");
      tick();
      rstn_v[0] = 1'b1;
      repeat (2) tick();

      // Fresh run reproduces the reference signature
      start_run(0, 16'h0000, 1'b1);
      wait_done(0);

      // LATENCY=3 with a seed whose low byte is zero for ADD, SUB, MUL and DIV
      start_run(1, 16'h0000, 1'b1);
      chk("add_zero_a", 32'(a_v[1]), 32'h0000_0042);
      chk("add_zero_b", 32'(b_v[1]), 32'h0000_0000);
      wait_en(1, 4);
      chk("div_guard_op", 32'(op_v[1]), 32'h0000_000C);
      chk("div_guard_a", 32'(a_v[1]), 32'h0000_0010);
      chk("div_guard_b", 32'(b_v[1]), 32'h0000_0001);
      wait_done(1);

      // Several vectors per opcode
      start_run(2, 16'h0000, 1'b1);
      wait_done(2);

      repeat (3) tick();
      chk("queues_drained", 32'(exp_iss[0].size() + exp_iss[1].size() + exp_iss[2].size()
                               + exp_dn[0].size() + exp_dn[1].size() + exp_dn[2].size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
